// File: rtl/issue_queue.sv
// Dual-slot in-order issue queue.
// Circular buffer of DEPTH {inst, pc, npc} entries. Fetch may write up to two
// entries per cycle at the tail, and launch may consume up to two entries per
// cycle from the head. Outputs are combinational reads of the head and head+1
// entries, gated to zero when the corresponding slot is empty.
module issue_queue #(
    parameter int DEPTH = 8,
    parameter int IW    = 32
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_flush,
    input  logic [1:0]               i_in_valid,
    input  logic [IW-1:0]            i_in1_inst,
    input  logic [IW-1:0]            i_in1_pc,
    input  logic [IW-1:0]            i_in1_npc,
    input  logic [IW-1:0]            i_in2_inst,
    input  logic [IW-1:0]            i_in2_pc,
    input  logic [IW-1:0]            i_in2_npc,
    input  logic [1:0]               i_pop,
    output logic                     o_out1_valid,
    output logic [IW-1:0]            o_out1_inst,
    output logic [IW-1:0]            o_out1_pc,
    output logic [IW-1:0]            o_out1_npc,
    output logic                     o_out2_valid,
    output logic [IW-1:0]            o_out2_inst,
    output logic [IW-1:0]            o_out2_pc,
    output logic [IW-1:0]            o_out2_npc,
    output logic                     o_full,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] L_ONE  = CW'(1);
    localparam logic [CW-1:0] L_TWO  = CW'(2);
    localparam logic [CW-1:0] L_FULL = CW'(DEPTH - 1);

    // Number of set bits in a two-bit slot mask.
    function automatic logic [1:0] f_popcnt2(input logic [1:0] v);
        return {1'b0, v[0]} + {1'b0, v[1]};
    endfunction

    // Entry storage (deliberately not reset; only pointers define occupancy).
    logic [IW-1:0] r_inst [DEPTH];
    logic [IW-1:0] r_pc   [DEPTH];
    logic [IW-1:0] r_npc  [DEPTH];

    logic [AW-1:0] r_head;
    logic [AW-1:0] r_tail;
    logic [CW-1:0] r_count;

    logic          w_v1;
    logic          w_v2;
    logic          w_full;
    logic          w_push_ok;
    logic          w_wr1;
    logic          w_wr2;
    logic [1:0]    w_push_n;
    logic [1:0]    w_pop_n;
    logic [AW-1:0] w_head1;
    logic [AW-1:0] w_slot2_idx;

    assign w_v1        = (r_count >= L_ONE);
    assign w_v2        = (r_count >= L_TWO);
    assign w_full      = (r_count >= L_FULL);
    assign w_push_ok   = !i_rst && !i_flush && !w_full;
    assign w_head1     = r_head + {{(AW-1){1'b0}}, 1'b1};
    // Slot 2 lands right after slot 1 when both are valid, else at the tail.
    assign w_slot2_idx = r_tail + {{(AW-1){1'b0}}, i_in_valid[0]};

    assign o_full  = w_full;
    assign o_count = r_count;

    // Pop amount: in order, and a pop bit on an empty slot is ignored.
    always_comb begin
        w_pop_n = 2'd0;
        if (i_pop[0] && w_v1) begin
            if (i_pop[1] && w_v2) begin
                w_pop_n = 2'd2;
            end else begin
                w_pop_n = 2'd1;
            end
        end else begin
            w_pop_n = 2'd0;
        end
    end

    // Push enables and amount: nothing is written while full, flushing or in reset.
    always_comb begin
        w_push_n = 2'd0;
        w_wr1    = 1'b0;
        w_wr2    = 1'b0;
        if (w_push_ok) begin
            w_push_n = f_popcnt2(i_in_valid);
            w_wr1    = i_in_valid[0];
            w_wr2    = i_in_valid[1];
        end else begin
            w_push_n = 2'd0;
            w_wr1    = 1'b0;
            w_wr2    = 1'b0;
        end
    end

    // Pointer and occupancy update; reset outranks flush, which outranks push/pop.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_head  <= r_head + {{(AW-2){1'b0}}, w_pop_n};
            r_tail  <= r_tail + {{(AW-2){1'b0}}, w_push_n};
            r_count <= r_count + {{(CW-2){1'b0}}, w_push_n} - {{(CW-2){1'b0}}, w_pop_n};
        end
    end

    // Entry writes in program order; slot 1 at tail, slot 2 after it.
    always_ff @(posedge i_clk) begin
        if (w_wr1) begin
            r_inst[r_tail] <= i_in1_inst;
            r_pc[r_tail]   <= i_in1_pc;
            r_npc[r_tail]  <= i_in1_npc;
        end
        if (w_wr2) begin
            r_inst[w_slot2_idx] <= i_in2_inst;
            r_pc[w_slot2_idx]   <= i_in2_pc;
            r_npc[w_slot2_idx]  <= i_in2_npc;
        end
    end

    // Head slot read, zeroed when empty.
    always_comb begin
        o_out1_valid = w_v1;
        o_out1_inst  = '0;
        o_out1_pc    = '0;
        o_out1_npc   = '0;
        if (w_v1) begin
            o_out1_inst = r_inst[r_head];
            o_out1_pc   = r_pc[r_head];
            o_out1_npc  = r_npc[r_head];
        end else begin
            o_out1_inst = '0;
            o_out1_pc   = '0;
            o_out1_npc  = '0;
        end
    end

    // Head+1 slot read, zeroed when fewer than two entries are held.
    always_comb begin
        o_out2_valid = w_v2;
        o_out2_inst  = '0;
        o_out2_pc    = '0;
        o_out2_npc   = '0;
        if (w_v2) begin
            o_out2_inst = r_inst[w_head1];
            o_out2_pc   = r_pc[w_head1];
            o_out2_npc  = r_npc[w_head1];
        end else begin
            o_out2_inst = '0;
            o_out2_pc   = '0;
            o_out2_npc  = '0;
        end
    end

endmodule

// File: tb/tb_issue_queue.sv
// Self-checking bench for issue_queue: directed scenarios with literal
// expectations, then randomized traffic compared each cycle against a
// queue-based reference model.
module tb_issue_queue;

    localparam int DEPTH = 8;
    localparam int IW    = 32;

    typedef struct packed {
        logic [IW-1:0] inst;
        logic [IW-1:0] pc;
        logic [IW-1:0] npc;
    } ent_t;

    logic          clk;
    logic          rst;
    logic          flush;
    logic [1:0]    in_valid;
    logic [IW-1:0] in1_inst, in1_pc, in1_npc;
    logic [IW-1:0] in2_inst, in2_pc, in2_npc;
    logic [1:0]    pop;
    logic          out1_valid, out2_valid, full;
    logic [IW-1:0] out1_inst, out1_pc, out1_npc;
    logic [IW-1:0] out2_inst, out2_pc, out2_npc;
    logic [$clog2(DEPTH):0] count;

    int   n_checks = 0;
    int   n_pass   = 0;
    ent_t mq[$];

    issue_queue #(.DEPTH(DEPTH), .IW(IW)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_flush     (flush),
        .i_in_valid  (in_valid),
        .i_in1_inst  (in1_inst),
        .i_in1_pc    (in1_pc),
        .i_in1_npc   (in1_npc),
        .i_in2_inst  (in2_inst),
        .i_in2_pc    (in2_pc),
        .i_in2_npc   (in2_npc),
        .i_pop       (pop),
        .o_out1_valid(out1_valid),
        .o_out1_inst (out1_inst),
        .o_out1_pc   (out1_pc),
        .o_out1_npc  (out1_npc),
        .o_out2_valid(out2_valid),
        .o_out2_inst (out2_inst),
        .o_out2_pc   (out2_pc),
        .o_out2_npc  (out2_npc),
        .o_full      (full),
        .o_count     (count)
    );

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic r, input logic f, input logic [1:0] v, input logic [1:0] p,
                         input logic [31:0] pc1, input logic [31:0] pc2);
        rst      = r;
        flush    = f;
        in_valid = v;
        pop      = p;
        in1_pc   = pc1;
        in1_npc  = pc1 + 32'd4;
        in1_inst = $urandom;
        in2_pc   = pc2;
        in2_npc  = pc2 + 32'd4;
        in2_inst = $urandom;
    endtask

    // Reference behaviour: clear on reset/flush; otherwise drop the popped
    // entries from the front and append accepted pushes at the back.
    task automatic model_update();
        int  npop;
        bit  was_full;
        if (rst || flush) begin
            mq.delete();
        end else begin
            npop     = 0;
            was_full = (mq.size() >= DEPTH - 1);
            if (pop[0] && mq.size() >= 1) npop = (pop[1] && mq.size() >= 2) ? 2 : 1;
            repeat (npop) void'(mq.pop_front());
            if (!was_full) begin
                if (in_valid[0]) mq.push_back({in1_inst, in1_pc, in1_npc});
                if (in_valid[1]) mq.push_back({in2_inst, in2_pc, in2_npc});
            end
        end
    endtask

    task automatic compare_all();
        ent_t e1, e2;
        e1 = '0;
        e2 = '0;
        if (mq.size() >= 1) e1 = mq[0];
        if (mq.size() >= 2) e2 = mq[1];
        chk("count",      32'(count),      32'(mq.size()));
        chk("full",       32'(full),       32'(mq.size() >= DEPTH - 1));
        chk("out1_valid", 32'(out1_valid), 32'(mq.size() >= 1));
        chk("out2_valid", 32'(out2_valid), 32'(mq.size() >= 2));
        chk("out1_inst",  out1_inst,       e1.inst);
        chk("out1_pc",    out1_pc,         e1.pc);
        chk("out1_npc",   out1_npc,        e1.npc);
        chk("out2_inst",  out2_inst,       e2.inst);
        chk("out2_pc",    out2_pc,         e2.pc);
        chk("out2_npc",   out2_npc,        e2.npc);
    endtask

    // One clock: model follows the edge, outputs are checked on the falling edge.
    task automatic step();
        @(posedge clk);
        model_update();
        @(negedge clk);
        compare_all();
    endtask

    initial begin
        drive(1'b1, 1'b0, 2'b00, 2'b00, 32'h0, 32'h0);
        step();
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_v1",    32'(out1_valid), 32'd0);
        chk("rst_full",  32'(full), 32'd0);
        chk("rst_pc1",   out1_pc, 32'd0);

        // First push right after reset.
        drive(1'b0, 1'b0, 2'b11, 2'b00, 32'h00, 32'h04);
        step();
        chk("p1_count", 32'(count), 32'd2);
        chk("p1_pc1",   out1_pc, 32'h00);
        chk("p1_pc2",   out2_pc, 32'h04);
        chk("p1_v2",    32'(out2_valid), 32'd1);
        chk("p1_full",  32'(full), 32'd0);

        // Fill: 4, 6 (not full), 8 (full), then an ignored push.
        drive(1'b0, 1'b0, 2'b11, 2'b00, 32'h08, 32'h0c);
        step();
        chk("fill_c4", 32'(count), 32'd4);
        drive(1'b0, 1'b0, 2'b11, 2'b00, 32'h10, 32'h14);
        step();
        chk("fill_c6", 32'(count), 32'd6);
        chk("fill_f6", 32'(full), 32'd0);
        drive(1'b0, 1'b0, 2'b11, 2'b00, 32'h18, 32'h1c);
        step();
        chk("fill_c8", 32'(count), 32'd8);
        chk("fill_f8", 32'(full), 32'd1);
        drive(1'b0, 1'b0, 2'b11, 2'b00, 32'h90, 32'h94);
        step();
        chk("fill_ign", 32'(count), 32'd8);
        chk("fill_pc1", out1_pc, 32'h00);

        // Drain to one entry, then pop=11 on a single entry.
        drive(1'b0, 1'b0, 2'b00, 2'b11, 32'h0, 32'h0);
        step();
        step();
        step();
        chk("drain_c2", 32'(count), 32'd2);
        chk("drain_pc", out1_pc, 32'h18);
        drive(1'b0, 1'b0, 2'b00, 2'b01, 32'h0, 32'h0);
        step();
        chk("drain_c1", 32'(count), 32'd1);
        drive(1'b0, 1'b0, 2'b00, 2'b11, 32'h0, 32'h0);
        step();
        chk("one_pop_c", 32'(count), 32'd0);
        chk("one_pop_v", 32'(out1_valid), 32'd0);
        chk("one_pop_d", out1_pc, 32'd0);

        // Move head to 6, then hold six entries spanning the wrap.
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 2'b11, 2'b00, 32'h40 + 32'(8 * i), 32'h44 + 32'(8 * i));
            step();
        end
        drive(1'b0, 1'b0, 2'b00, 2'b11, 32'h0, 32'h0);
        step();
        step();
        step();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 2'b11, 2'b00, 32'h100 + 32'(8 * i), 32'h104 + 32'(8 * i));
            step();
        end
        chk("wrap_c6", 32'(count), 32'd6);
        drive(1'b0, 1'b0, 2'b11, 2'b11, 32'h200, 32'h204);
        step();
        chk("wrap_cnt", 32'(count), 32'd6);
        chk("wrap_pc1", out1_pc, 32'h108);
        chk("wrap_pc2", out2_pc, 32'h10c);

        // Flush wins over same-cycle push and pop.
        drive(1'b0, 1'b0, 2'b00, 2'b01, 32'h0, 32'h0);
        step();
        chk("fl_c5", 32'(count), 32'd5);
        drive(1'b0, 1'b1, 2'b11, 2'b01, 32'h300, 32'h304);
        step();
        chk("fl_cnt", 32'(count), 32'd0);
        chk("fl_v1",  32'(out1_valid), 32'd0);
        chk("fl_v2",  32'(out2_valid), 32'd0);

        // Slot 2 alone.
        drive(1'b0, 1'b0, 2'b10, 2'b00, 32'h500, 32'h24);
        step();
        chk("s2_cnt", 32'(count), 32'd1);
        chk("s2_pc1", out1_pc, 32'h24);
        chk("s2_v2",  32'(out2_valid), 32'd0);

        // Illegal pop=10 is no pop.
        drive(1'b0, 1'b0, 2'b11, 2'b00, 32'h30, 32'h34);
        step();
        drive(1'b0, 1'b0, 2'b00, 2'b10, 32'h0, 32'h0);
        step();
        chk("pop10_c",  32'(count), 32'd3);
        chk("pop10_pc", out1_pc, 32'h24);

        // Reset mid-operation beats push and pop; push right after is accepted.
        drive(1'b1, 1'b0, 2'b11, 2'b11, 32'h600, 32'h604);
        step();
        chk("rst2_c", 32'(count), 32'd0);
        drive(1'b0, 1'b0, 2'b01, 2'b00, 32'h50, 32'h0);
        step();
        chk("rst2_p", out1_pc, 32'h50);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            drive(1'($urandom_range(0, 63) == 0), 1'($urandom_range(0, 15) == 0),
                  2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), $urandom, $urandom);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/issue_queue.md
ISSUE_QUEUE -- requirements
Module: issue_queue

Interface
REQ-001 Parameter DEPTH, default 8, entry count (power of two, >= 4).
REQ-002 Parameter IW, default 32, width of inst, pc and npc fields.
REQ-003 clk  in  1  sole clock; all state updates on posedge clk.
REQ-004 rst  in  1  reset, synchronous and active-high.
REQ-005 flush  in  1  branch redirect from execute; discards all queued entries.
REQ-006 in_valid  in  2  bit0 = fetch slot 1 valid, bit1 = fetch slot 2 valid.
REQ-007 in1_inst / in1_pc / in1_npc  in  IW each  fetch slot 1 fields.
REQ-008 in2_inst / in2_pc / in2_npc  in  IW each  fetch slot 2 fields.
REQ-009 pop  in  2  launch acknowledge: bit0 consumes out1, bit1 consumes out2.
REQ-010 out1_valid  out  1  head entry present.
REQ-011 out1_inst / out1_pc / out1_npc  out  IW each  head entry fields.
REQ-012 out2_valid  out  1  head+1 entry present.
REQ-013 out2_inst / out2_pc / out2_npc  out  IW each  head+1 entry fields.
REQ-014 full  out  1  fewer than 2 free entries; fetch stalls.
REQ-015 count  out  log2(DEPTH)+1  occupied entries, 0..DEPTH.

Function
REQ-016 Storage is a circular buffer of DEPTH entries {inst, pc, npc}; 3-bit (log2 DEPTH) head/tail pointers wrap modulo DEPTH.
REQ-017 Push: when full=0 and flush=0, valid slots are written in program order at tail: slot1 first, then slot2; in_valid=2'b10 writes in2 at tail alone; tail advances by popcount(in_valid).
REQ-018 When full=1, in_valid is ignored; no write, tail unchanged.
REQ-019 full = (count >= DEPTH-1), combinational from registered count, so any accepted push always fits.
REQ-020 out1_valid = (count >= 1); out2_valid = (count >= 2); data outputs are combinational reads of entries head and head+1 (mod DEPTH).
REQ-021 Data outputs of an invalid slot are driven to all zeros.
REQ-022 Pop is in order: pop=2'b01 advances head by 1; pop=2'b11 advances head by 2; pop=2'b10 is illegal and treated as no pop.
REQ-023 Pop bits for a slot whose valid is 0 are ignored (pop=2'b11 with count=1 advances head by 1).
REQ-024 Simultaneous push and pop in one cycle both take effect; next count = count + pushes - pops.
REQ-025 Push into the entry being popped in the same cycle is legal when the pointers wrap; read data reflects the pre-edge contents.
REQ-026 flush=1: next cycle head=tail=0, count=0; same-cycle pushes and pops are discarded.
REQ-027 Latency: an entry pushed at edge N is visible on out1/out2 from the cycle after edge N (no bypass from inputs to outputs).
REQ-028 Entry data storage is not reset; only pointers and count are.

Reset
REQ-029 rst=1 at posedge: head=0, tail=0, count=0; hence out1_valid=0, out2_valid=0, full=0, all out data 0.
REQ-030 rst has priority over flush, push and pop; rst asserted mid-operation discards all contents in one cycle.
REQ-031 First push is accepted at the first posedge with rst=0.

Verification
REQ-032 Reset, then push in_valid=11 (pc 0x00,0x04) -> next cycle count=2, out1_pc=0x00, out2_pc=0x04, both valid, full=0.
REQ-033 Push 11 four times with pop=00 -> count climbs 2,4,6; full=1 at count=6? no: full=1 when count>=7; after third push count=6 full=0, fourth push accepted count=8, full=1, fifth push ignored, count stays 8.
REQ-034 count=1, pop=11 -> head advances 1, count=0, out1_valid=0, out1 data=0.
REQ-035 count=6 head=6, push 11 and pop 11 same cycle -> tail wraps 4->6 (mod 8), count stays 6, out1_pc = former third entry pc.
REQ-036 count=5, flush=1 together with push 11 and pop 01 -> next cycle count=0, head=tail=0, both valid 0.
REQ-037 in_valid=10 with in2_pc=0x24 on empty queue -> next cycle count=1, out1_pc=0x24, out2_valid=0.
